gfxdemo_wb_ctrl: RTL and testbench

- Wishbone classic slave sitting directly upstream of the gfxdemo video core, between the Caravel wishbone bus and the core.
- Holds the core's control/scroll registers, a 16-entry RGB444 palette with a video-side read port, a vblank-driven frame counter, and interrupt status/enable logic.
- Its configuration outputs feed gfxdemo; its irq drives the wrapper's irq[0].

---
 rtl/gfxdemo_pkg.sv | 55 +++++
 rtl/gfxdemo_palette.sv | 40 ++++
 rtl/gfxdemo_wb_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gfxdemo_wb_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfxdemo_pkg.sv
// Shared constants and register decode for the gfxdemo wishbone control block.
package gfxdemo_pkg;

  localparam logic [31:0] DEFAULT_ID = 32'h4746_5830;

  localparam logic [7:0] OFF_CTRL       = 8'h00;
  localparam logic [7:0] OFF_SCROLL     = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN     = 8'h08;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h0C;
  localparam logic [7:0] OFF_FRAME      = 8'h10;
  localparam logic [7:0] OFF_ID         = 8'h14;
  localparam logic [7:0] OFF_PAL_BASE   = 8'h40;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_LSB  = 1;
  localparam int CTRL_DAC_BIT   = 3;
  localparam int IRQ_VBLANK_BIT = 0;
  localparam int IRQ_WRAP_BIT   = 1;

  localparam int PAL_DEPTH = 16;
  localparam int PAL_WIDTH = 12;
  localparam int PAL_IDX_W = 4;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_SCROLL,
    REG_IRQ_EN,
    REG_IRQ_STATUS,
    REG_FRAME,
    REG_ID,
    REG_PAL,
    REG_NONE
  } regSel_e;

  // The palette occupies byte offsets 0x40-0x7C, i.e. every offset whose top two bits are 01.
  function automatic regSel_e decodeReg(input logic [7:0] off);
    regSel_e sel;
    sel = REG_NONE;
    if (off[7:6] == OFF_PAL_BASE[7:6]) begin
      sel = REG_PAL;
    end else begin
      case (off)
        OFF_CTRL:       sel = REG_CTRL;
        OFF_SCROLL:     sel = REG_SCROLL;
        OFF_IRQ_EN:     sel = REG_IRQ_EN;
        OFF_IRQ_STATUS: sel = REG_IRQ_STATUS;
        OFF_FRAME:      sel = REG_FRAME;
        OFF_ID:         sel = REG_ID;
        default:        sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/gfxdemo_palette.sv
// 16x12 RGB444 palette: byte-masked bus write port, combinational bus readback,
// registered video-side lookup.
module gfxdemo_palette
  import gfxdemo_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en_i,
  input  logic [PAL_IDX_W-1:0] wr_idx_i,
  input  logic [PAL_WIDTH-1:0] wr_data_i,
  input  logic [1:0]           wr_sel_i,
  input  logic [PAL_IDX_W-1:0] bus_idx_i,
  output logic [PAL_WIDTH-1:0] bus_data_o,
  input  logic [PAL_IDX_W-1:0] rd_idx_i,
  output logic [PAL_WIDTH-1:0] rd_data_o
);

  logic [PAL_WIDTH-1:0] mem_q [PAL_DEPTH];
  logic [PAL_WIDTH-1:0] rdData_q;

  // The lookup reads the pre-write contents, so a same-cycle write shows up on the next lookup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdData_q <= '0;
    end else begin
      if (wr_en_i) begin
        if (wr_sel_i[0]) mem_q[wr_idx_i][7:0]  <= wr_data_i[7:0];
        if (wr_sel_i[1]) mem_q[wr_idx_i][11:8] <= wr_data_i[11:8];
      end
      rdData_q <= mem_q[rd_idx_i];
    end
  end

  assign bus_data_o = mem_q[bus_idx_i];
  assign rd_data_o  = rdData_q;

endmodule

// File: rtl/gfxdemo_wb_ctrl.sv
// Wishbone classic slave holding gfxdemo control, scroll, palette, frame counter and IRQ state.
// Define GFXDEMO_WB_CTRL_SHADOW_EN to latch cfg_* outputs only at vblank (tear-free updates).
module gfxdemo_wb_ctrl
  import gfxdemo_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ID_VALUE  = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  input  logic        vblank_pulse,
  input  logic [3:0]  pal_idx,
  output logic [11:0] pal_rgb,
  output logic [3:0]  cfg_ctrl,
  output logic [9:0]  cfg_scroll_x,
  output logic [9:0]  cfg_scroll_y,
  output logic        irq
);

  logic [3:0]  ctrl_q, ctrl_d;
  logic [9:0]  scrollX_q, scrollX_d;
  logic [9:0]  scrollY_q, scrollY_d;
  logic [1:0]  irqEn_q, irqEn_d;
  logic [1:0]  irqStatus_q, irqStatus_d;
  logic [15:0] frame_q, frame_d;
  logic        ack_q;
  logic [31:0] datR_q;
  logic        irq_q;
  logic [3:0]  cfgCtrl_q;
  logic [9:0]  cfgScrollX_q, cfgScrollY_q;

  logic        hit, wrHit, rdHit;
  regSel_e     regSel;
  logic [1:0]  irqSet, irqClr;
  logic [31:0] readData;
  logic        palWe;
  logic [11:0] palBusData;
  logic        cfgLoad;
  logic        unusedBits;

  // The !ack term makes a held strobe hit only every other cycle.
  assign hit    = wb_cyc & wb_stb & (wb_adr[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wrHit  = hit & wb_we;
  assign rdHit  = hit & ~wb_we;
  assign regSel = decodeReg({wb_adr[7:2], 2'b00});
  assign palWe  = wrHit & (regSel == REG_PAL);

  assign unusedBits = ^{wb_adr[1:0], wb_dat_w[31:26], wb_dat_w[15:12]};

  always_comb begin
    ctrl_d    = ctrl_q;
    scrollX_d = scrollX_q;
    scrollY_d = scrollY_q;
    irqEn_d   = irqEn_q;
    if (wrHit) begin
      case (regSel)
        REG_CTRL: begin
          if (wb_sel[0]) ctrl_d = wb_dat_w[3:0];
        end
        REG_SCROLL: begin
          if (wb_sel[0]) scrollX_d[7:0] = wb_dat_w[7:0];
          if (wb_sel[1]) scrollX_d[9:8] = wb_dat_w[9:8];
          if (wb_sel[2]) scrollY_d[7:0] = wb_dat_w[23:16];
          if (wb_sel[3]) scrollY_d[9:8] = wb_dat_w[25:24];
        end
        REG_IRQ_EN: begin
          if (wb_sel[0]) irqEn_d = wb_dat_w[1:0];
        end
        default: ;
      endcase
    end
  end

  // A set arriving with a W1C of the same bit wins because it is OR-ed in last.
  always_comb begin
    irqSet                 = '0;
    irqSet[IRQ_VBLANK_BIT] = vblank_pulse;
    irqSet[IRQ_WRAP_BIT]   = vblank_pulse & (frame_q == 16'hFFFF);
    irqClr                 = '0;
    if (wrHit && (regSel == REG_IRQ_STATUS) && wb_sel[0]) begin
      irqClr = wb_dat_w[1:0];
    end
    irqStatus_d = (irqStatus_q & ~irqClr) | irqSet;
    frame_d     = vblank_pulse ? frame_q + 16'd1 : frame_q;
  end

  always_comb begin
    readData = '0;
    case (regSel)
      REG_CTRL:       readData = {28'd0, ctrl_q};
      REG_SCROLL:     readData = {6'd0, scrollY_q, 6'd0, scrollX_q};
      REG_IRQ_EN:     readData = {30'd0, irqEn_q};
      REG_IRQ_STATUS: readData = {30'd0, irqStatus_q};
      REG_FRAME:      readData = {16'd0, frame_q};
      REG_ID:         readData = ID_VALUE;
      REG_PAL:        readData = {20'd0, palBusData};
      default:        readData = '0;
    endcase
  end

`ifdef GFXDEMO_WB_CTRL_SHADOW_EN
  assign cfgLoad = vblank_pulse;
`else
  assign cfgLoad = 1'b1;
`endif

  // cfg_* sample the live registers before this cycle's write lands, so a
  // write coinciding with vblank is picked up at the following vblank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q       <= '0;
      scrollX_q    <= '0;
      scrollY_q    <= '0;
      irqEn_q      <= '0;
      irqStatus_q  <= '0;
      frame_q      <= '0;
      ack_q        <= 1'b0;
      datR_q       <= '0;
      irq_q        <= 1'b0;
      cfgCtrl_q    <= '0;
      cfgScrollX_q <= '0;
      cfgScrollY_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      scrollX_q   <= scrollX_d;
      scrollY_q   <= scrollY_d;
      irqEn_q     <= irqEn_d;
      irqStatus_q <= irqStatus_d;
      frame_q     <= frame_d;
      ack_q       <= hit;
      datR_q      <= rdHit ? readData : 32'd0;
      irq_q       <= |(irqStatus_q & irqEn_q);
      if (cfgLoad) begin
        cfgCtrl_q    <= ctrl_q;
        cfgScrollX_q <= scrollX_q;
        cfgScrollY_q <= scrollY_q;
      end
    end
  end

  gfxdemo_palette uPalette (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en_i    (palWe),
    .wr_idx_i   (wb_adr[5:2]),
    .wr_data_i  (wb_dat_w[11:0]),
    .wr_sel_i   (wb_sel[1:0]),
    .bus_idx_i  (wb_adr[5:2]),
    .bus_data_o (palBusData),
    .rd_idx_i   (pal_idx),
    .rd_data_o  (pal_rgb)
  );

  assign wb_ack       = ack_q;
  assign wb_dat_r     = datR_q;
  assign irq          = irq_q;
  assign cfg_ctrl     = cfgCtrl_q;
  assign cfg_scroll_x = cfgScrollX_q;
  assign cfg_scroll_y = cfgScrollY_q;

endmodule

// File: tb/tb_gfxdemo_wb_ctrl.sv
// Directed bench for gfxdemo_wb_ctrl: table of bus vectors plus hand-written multi-cycle sequences.
module tb_gfxdemo_wb_ctrl;
  import gfxdemo_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        vblank_pulse;
  logic [3:0]  pal_idx;
  logic [11:0] pal_rgb;
  logic [3:0]  cfg_ctrl;
  logic [9:0]  cfg_scroll_x;
  logic [9:0]  cfg_scroll_y;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gfxdemo_wb_ctrl #(.BASE_ADDR(BASE), .ID_VALUE(32'h4746_5830)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_adr       (wb_adr),
    .wb_dat_w     (wb_dat_w),
    .wb_sel       (wb_sel),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .wb_dat_r     (wb_dat_r),
    .wb_ack       (wb_ack),
    .vblank_pulse (vblank_pulse),
    .pal_idx      (pal_idx),
    .pal_rgb      (pal_rgb),
    .cfg_ctrl     (cfg_ctrl),
    .cfg_scroll_x (cfg_scroll_x),
    .cfg_scroll_y (cfg_scroll_y),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        expAck;
    logic [31:0] expData;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // One classic bus cycle; gives up after 8 cycles without ack.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, output logic gotAck,
                               output logic [31:0] rdata, output int latency);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    gotAck = 1'b0; rdata = '0; latency = 0;
    for (int i = 1; i <= 8 && !gotAck; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        gotAck = 1'b1; rdata = wb_dat_r; latency = i;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic writeReg(input string name, input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic ok; logic [31:0] rd; int lat;
    applyStimulus(1'b1, BASE + {24'd0, off}, dat, sel, ok, rd, lat);
    checkOutput({name, "_ack"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic readReg(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic ok; logic [31:0] rd; int lat;
    applyStimulus(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, ok, rd, lat);
    checkOutput({name, "_ack"}, {31'd0, ok}, 32'd1);
    checkOutput(name, rd, exp);
  endtask

  task automatic pulseVblank();
    @(negedge clk); vblank_pulse = 1'b1;
    @(negedge clk); vblank_pulse = 1'b0;
  endtask

  initial begin
    logic        ok;
    logic [31:0] rd;
    int          lat;
    logic [3:0]  expOld, expNew;

    vecs[0]  = '{1'b0, BASE + 32'h14,  32'h0,         4'hF, 1'b1, 32'h4746_5830};
    vecs[1]  = '{1'b0, BASE + 32'h18,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, BASE + 32'h00,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, BASE + 32'h04,  32'h00F0_0123, 4'h3, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, BASE + 32'h04,  32'h0,         4'hF, 1'b1, 32'h0000_0123};
    vecs[5]  = '{1'b1, BASE + 32'h04,  32'h02AB_0000, 4'hC, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, BASE + 32'h04,  32'h0,         4'hF, 1'b1, 32'h02AB_0123};
    vecs[7]  = '{1'b1, BASE + 32'h54,  32'hFFFF_FABC, 4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, BASE + 32'h54,  32'h0,         4'hF, 1'b1, 32'h0000_0ABC};
    vecs[9]  = '{1'b1, BASE + 32'h58,  32'h0000_0DEF, 4'h1, 1'b1, 32'h0};
    vecs[10] = '{1'b0, BASE + 32'h58,  32'h0,         4'hF, 1'b1, 32'h0000_00EF};
    vecs[11] = '{1'b1, BASE + 32'h18,  32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
    vecs[12] = '{1'b0, BASE + 32'h18,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[13] = '{1'b1, BASE + 32'h14,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, BASE + 32'h14,  32'h0,         4'hF, 1'b1, 32'h4746_5830};
    vecs[15] = '{1'b1, BASE + 32'h10,  32'h0000_1234, 4'hF, 1'b1, 32'h0};
    vecs[16] = '{1'b0, BASE + 32'h10,  32'h0,         4'hF, 1'b1, 32'h0};
    vecs[17] = '{1'b0, BASE + 32'h100, 32'h0,         4'hF, 1'b0, 32'h0};
    vecs[18] = '{1'b1, BASE + 32'h00,  32'h0000_00FF, 4'h1, 1'b1, 32'h0};
    vecs[19] = '{1'b0, BASE + 32'h00,  32'h0,         4'hF, 1'b1, 32'h0000_000F};
    vecs[20] = '{1'b1, BASE + 32'h200, 32'h0000_0005, 4'hF, 1'b0, 32'h0};

    reset_n = 1'b0; wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    vblank_pulse = 1'b0; pal_idx = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack",  {31'd0, wb_ack}, 32'd0);
    checkOutput("rst_datr", wb_dat_r, 32'd0);
    checkOutput("rst_irq",  {31'd0, irq}, 32'd0);
    checkOutput("rst_pal",  {20'd0, pal_rgb}, 32'd0);
    checkOutput("rst_cfg",  {8'd0, cfg_ctrl, cfg_scroll_x, cfg_scroll_y}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, ok, rd, lat);
      checkOutput($sformatf("vec%0d_ack", i), {31'd0, ok}, {31'd0, vecs[i].expAck});
      if (vecs[i].expAck) begin
        checkOutput($sformatf("vec%0d_latency", i), lat, 32'd1);
        if (!vecs[i].we) checkOutput($sformatf("vec%0d_data", i), rd, vecs[i].expData);
      end
    end

`ifdef GFXDEMO_WB_CTRL_SHADOW_EN
    checkOutput("cfg_scroll_after_table", {12'd0, cfg_scroll_y, cfg_scroll_x}, 32'd0);
    expOld = 4'h0; expNew = 4'h0;
`else
    checkOutput("cfg_scroll_after_table", {12'd0, cfg_scroll_y, cfg_scroll_x}, {12'd0, 10'h2AB, 10'h123});
    expOld = 4'hF; expNew = 4'h5;
`endif

    // cfg_ctrl timing around a CTRL write
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE; wb_dat_w = 32'h5; wb_sel = 4'h1;
    @(negedge clk);
    checkOutput("ctrl_wr_ack", {31'd0, wb_ack}, 32'd1);
    checkOutput("cfg_ctrl_in_ack", {28'd0, cfg_ctrl}, {28'd0, expOld});
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    checkOutput("cfg_ctrl_after_ack", {28'd0, cfg_ctrl}, {28'd0, expNew});
    checkOutput("ack_one_cycle", {31'd0, wb_ack}, 32'd0);

    // video-side palette lookup, including a same-cycle write to the looked-up entry
    pal_idx = 4'd5;
    @(negedge clk);
    checkOutput("pal_rgb_5", {20'd0, pal_rgb}, 32'h0ABC);
    pal_idx = 4'd7;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE + 32'h5C; wb_dat_w = 32'h0123; wb_sel = 4'h3;
    @(negedge clk);
    checkOutput("pal_wr_ack", {31'd0, wb_ack}, 32'd1);
    checkOutput("pal_rgb_7_old", {20'd0, pal_rgb}, 32'h0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    checkOutput("pal_rgb_7_new", {20'd0, pal_rgb}, 32'h0123);

    // vblank, frame counter and IRQ
    writeReg("irq_en", OFF_IRQ_EN, 32'h1, 4'h1);
    pulseVblank();
    checkOutput("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
    readReg("frame1", OFF_FRAME, 32'd1);
    readReg("status1", OFF_IRQ_STATUS, 32'd1);

    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE + 32'h0C; wb_dat_w = 32'h1; wb_sel = 4'h1;
    vblank_pulse = 1'b1;
    @(negedge clk);
    vblank_pulse = 1'b0;
    checkOutput("setwins_ack", {31'd0, wb_ack}, 32'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    readReg("status_setwins", OFF_IRQ_STATUS, 32'd1);
    readReg("frame2", OFF_FRAME, 32'd2);
    checkOutput("irq_still", {31'd0, irq}, 32'd1);

    writeReg("w1c_nosel0", OFF_IRQ_STATUS, 32'h3, 4'h2);
    readReg("status_nosel0", OFF_IRQ_STATUS, 32'd1);
    writeReg("w1c", OFF_IRQ_STATUS, 32'h1, 4'h1);
    readReg("status_cleared", OFF_IRQ_STATUS, 32'd0);
    checkOutput("irq_cleared", {31'd0, irq}, 32'd0);

    // frame counter wrap: 65533 more increments take it from 2 to 0xFFFF
    @(negedge clk); vblank_pulse = 1'b1;
    repeat (65533) @(negedge clk);
    vblank_pulse = 1'b0;
    readReg("frame_ffff", OFF_FRAME, 32'h0000_FFFF);
    readReg("status_prewrap", OFF_IRQ_STATUS, 32'd1);
    writeReg("w1c_all", OFF_IRQ_STATUS, 32'h3, 4'h1);
    pulseVblank();
    readReg("frame_wrap", OFF_FRAME, 32'd0);
    readReg("status_wrap", OFF_IRQ_STATUS, 32'd3);

    // shadowing: cfg_ctrl follows CTRL only at vblank when shadowing is built in
    writeReg("ctrl1", OFF_CTRL, 32'h1, 4'h1);
    @(negedge clk);
`ifdef GFXDEMO_WB_CTRL_SHADOW_EN
    checkOutput("cfg_hold", {28'd0, cfg_ctrl}, 32'h5);
`else
    checkOutput("cfg_hold", {28'd0, cfg_ctrl}, 32'h1);
`endif
    pulseVblank();
    checkOutput("cfg_vblank", {28'd0, cfg_ctrl}, 32'h1);
    readReg("ctrl_live", OFF_CTRL, 32'h1);

    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = BASE; wb_dat_w = 32'h3; wb_sel = 4'h1;
    vblank_pulse = 1'b1;
    @(negedge clk);
    vblank_pulse = 1'b0;
    checkOutput("ctrl3_ack", {31'd0, wb_ack}, 32'd1);
    checkOutput("cfg_prewrite", {28'd0, cfg_ctrl}, 32'h1);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
`ifdef GFXDEMO_WB_CTRL_SHADOW_EN
    checkOutput("cfg_after_coincident", {28'd0, cfg_ctrl}, 32'h1);
`else
    checkOutput("cfg_after_coincident", {28'd0, cfg_ctrl}, 32'h3);
`endif
    readReg("ctrl_live3", OFF_CTRL, 32'h3);
    pulseVblank();
    checkOutput("cfg_next_vblank", {28'd0, cfg_ctrl}, 32'h3);

    // reset asserted in the middle of an acked read
    pal_idx = 4'd5;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = BASE + 32'h14; wb_sel = 4'hF;
    @(negedge clk);
    checkOutput("ack_before_reset", {31'd0, wb_ack}, 32'd1);
    checkOutput("irq_before_reset", {31'd0, irq}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_ack",  {31'd0, wb_ack}, 32'd0);
    checkOutput("mid_rst_datr", wb_dat_r, 32'd0);
    checkOutput("mid_rst_irq",  {31'd0, irq}, 32'd0);
    checkOutput("mid_rst_pal",  {20'd0, pal_rgb}, 32'd0);
    checkOutput("mid_rst_cfg",  {8'd0, cfg_ctrl, cfg_scroll_x, cfg_scroll_y}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    readReg("ctrl_after_rst", OFF_CTRL, 32'd0);
    readReg("frame_after_rst", OFF_FRAME, 32'd0);
    readReg("pal5_after_rst", 8'h54, 32'd0);
    @(negedge clk);
    checkOutput("pal_rgb_after_rst", {20'd0, pal_rgb}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
